// File: rtl/fb_pkg.sv
// Shared framebuffer definitions for the fill engine and the VGA controller.
// Contents: framebuffer geometry, address/pixel widths, the fill-engine state
// encoding, the latched command record and the row-major base-address helper.
package fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int ADDR_W    = 15;
  localparam int PIXEL_W   = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WAIT_VB = 3'd2,
    FILL    = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0]         x;
    logic [6:0]         y;
    logic [7:0]         w;
    logic [6:0]         h;
    logic [PIXEL_W-1:0] color;
    logic               sync;
  } cmd_t;

  // y*160 + x built from shifts: 160 = 128 + 32. Peaks at 19199, so it fits.
  function automatic logic [ADDR_W-1:0] pixel_base(input logic [7:0] x,
                                                   input logic [6:0] y);
    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;
    x_ext = ADDR_W'(x);
    y_ext = ADDR_W'(y);
    return (y_ext << 7) + (y_ext << 5) + x_ext;
  endfunction

endpackage

// File: rtl/fb_cmd_if.sv
// Rectangle-fill command channel (valid/ready handshake).
// master: drives valid and the command fields, samples ready.
// slave : samples valid and the fields, drives ready.
//   valid  command presented
//   ready  engine can accept a command
//   x, y   top-left pixel (column 8b, row 7b)
//   w, h   size in pixels / rows
//   color  RGB444 fill colour
//   sync   hold the first write until vertical blanking
interface fb_cmd_if import fb_pkg::*; ();

  logic               valid;
  logic               ready;
  logic [7:0]         x;
  logic [6:0]         y;
  logic [7:0]         w;
  logic [6:0]         h;
  logic [PIXEL_W-1:0] color;
  logic               sync;

  modport master (output valid, x, y, w, h, color, sync, input  ready);
  modport slave  (input  valid, x, y, w, h, color, sync, output ready);

endinterface

// File: rtl/fb_addr_gen.sv
// Raster address generator for one clipped rectangle.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   base           address of the top-left pixel, loaded on start
//   w_eff, h_eff   clipped width/height (non-zero whenever start/step are used)
//   start          load base and clear the column/row counters
//   step           advance to the next pixel in raster order
//   addr           current pixel address (registered)
//   last           current pixel is the bottom-right one
module fb_addr_gen import fb_pkg::*; (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base,
  input  logic [8:0]        w_eff,
  input  logic [8:0]        h_eff,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [8:0]        col;
  logic [8:0]        row;
  logic [ADDR_W-1:0] row_base;
  logic              end_of_row;

  assign end_of_row = (col == w_eff - 9'd1);
  assign last       = end_of_row && (row == h_eff - 9'd1);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (start) begin
      col      <= '0;
      row      <= '0;
      row_base <= base;
      addr     <= base;
    end else if (step) begin
      if (end_of_row) begin
        // Jump to the same column one framebuffer row further down.
        col      <= '0;
        row      <= row + 9'd1;
        row_base <= row_base + ADDR_W'(FB_WIDTH);
        addr     <= row_base + ADDR_W'(FB_WIDTH);
      end else begin
        col  <= col + 9'd1;
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_fill_engine.sv
// Rectangle-fill engine writing framebuffer port A, one pixel per clock.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   cmd            fill command channel (slave side)
//   v_blank        vertical blanking flag from the VGA controller
//   fb_addr        port A address (registered)
//   fb_data        port A write data (registered)
//   fb_we          port A write enable (registered)
//   busy           engine not idle
//   done_irq       one-cycle pulse when a command finishes normally
module fb_fill_engine import fb_pkg::*; (
  input  logic               clock,
  input  logic               reset,
  fb_cmd_if.slave            cmd,
  input  logic               v_blank,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [PIXEL_W-1:0] fb_data,
  output logic               fb_we,
  output logic               busy,
  output logic               done_irq
);

  state_t state;
  state_t state_next;
  cmd_t   cmd_q;

  logic [8:0]        x_room;
  logic [8:0]        y_room;
  logic [8:0]        w_clip;
  logic [8:0]        h_clip;
  logic [8:0]        w_eff;
  logic [8:0]        h_eff;
  logic              out_of_range;
  logic              zero_area;
  logic [ADDR_W-1:0] base;
  logic              gen_start;
  logic              gen_step;
  logic              gen_last;

  assign cmd.ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Command fields are captured only on the accepting IDLE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_q <= '0;
    end else if (state == IDLE && cmd.valid) begin
      cmd_q.x     <= cmd.x;
      cmd_q.y     <= cmd.y;
      cmd_q.w     <= cmd.w;
      cmd_q.h     <= cmd.h;
      cmd_q.color <= cmd.color;
      cmd_q.sync  <= cmd.sync;
    end
  end

  // Clipping works on the latched command, so it is stable from SETUP onward
  // and the generator can keep using w_eff/h_eff throughout FILL.
  assign x_room       = 9'(FB_WIDTH) - {1'b0, cmd_q.x};
  assign y_room       = 9'(FB_HEIGHT) - {2'b0, cmd_q.y};
  assign w_clip       = ({1'b0, cmd_q.w} < x_room) ? {1'b0, cmd_q.w} : x_room;
  assign h_clip       = ({2'b0, cmd_q.h} < y_room) ? {2'b0, cmd_q.h} : y_room;
  assign out_of_range = ({1'b0, cmd_q.x} >= 9'(FB_WIDTH)) ||
                        ({2'b0, cmd_q.y} >= 9'(FB_HEIGHT));
  assign w_eff        = out_of_range ? 9'd0 : w_clip;
  assign h_eff        = out_of_range ? 9'd0 : h_clip;
  assign zero_area    = (w_eff == 9'd0) || (h_eff == 9'd0);
  assign base         = pixel_base(cmd_q.x, cmd_q.y);

  fb_addr_gen u_addr_gen (
    .clock (clock),
    .reset (reset),
    .base  (base),
    .w_eff (w_eff),
    .h_eff (h_eff),
    .start (gen_start),
    .step  (gen_step),
    .addr  (fb_addr),
    .last  (gen_last)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    gen_start  = 1'b0;
    gen_step   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd.valid) state_next = SETUP;
      end
      SETUP: begin
        if (zero_area) begin
          state_next = DONE;
        end else if (cmd_q.sync) begin
          state_next = WAIT_VB;
        end else begin
          state_next = FILL;
          gen_start  = 1'b1;
        end
      end
      WAIT_VB: begin
        if (v_blank) begin
          state_next = FILL;
          gen_start  = 1'b1;
        end
      end
      FILL: begin
        if (gen_last) state_next = DONE;
        else          gen_step   = 1'b1;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // cycle in which that state is current.
  always_ff @(posedge clock) begin
    if (reset) begin
      fb_we    <= 1'b0;
      fb_data  <= '0;
      done_irq <= 1'b0;
    end else begin
      fb_we    <= (state_next == FILL);
      done_irq <= (state_next == DONE);
      if (gen_start) fb_data <= cmd_q.color;
    end
  end

endmodule

// File: tb/tb_fb_fill_engine.sv
// Self-checking bench for fb_fill_engine: the driver pushes expected writes
// and done pulses (with their cycle numbers) into queues, and a negedge
// monitor pops and compares them as the DUT produces them.
module tb_fb_fill_engine;
  import fb_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               v_blank = 1'b0;
  logic [ADDR_W-1:0]  fb_addr;
  logic [PIXEL_W-1:0] fb_data;
  logic               fb_we;
  logic               busy;
  logic               done_irq;

  fb_cmd_if cmd_bus ();

  fb_fill_engine dut (
    .clock    (clock),
    .reset    (reset),
    .cmd      (cmd_bus),
    .v_blank  (v_blank),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_we    (fb_we),
    .busy     (busy),
    .done_irq (done_irq)
  );

  always #5 clock = ~clock;

  // Cycle number; the cycle observed at a negedge is the one that began at
  // the preceding posedge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  bit  mon_en = 1'b0;
  wr_t mon_e;
  int  mon_d;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (fb_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", int'(fb_addr), -1);
        end else begin
          mon_e = wr_q.pop_front();
          check("wr_addr", int'(fb_addr), mon_e.addr);
          check("wr_data", int'(fb_data), mon_e.data);
          check("wr_cycle", cyc, mon_e.cyc);
        end
      end
      if (done_irq) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", cyc, -1);
        end else begin
          mon_d = done_q.pop_front();
          check("done_cycle", cyc, mon_d);
        end
      end
    end
  end

  // Reference model: acc is the IDLE cycle in which the command is accepted,
  // extra the number of WAIT_VB cycles.
  task automatic push_expect(input int acc, input int x, input int y,
                             input int w, input int h, input int color,
                             input int extra, input int max_wr,
                             input bit with_done);
    int  weff;
    int  heff;
    int  n;
    wr_t e;
    weff = 0;
    heff = 0;
    if (x < FB_WIDTH && y < FB_HEIGHT) begin
      weff = (w < FB_WIDTH - x) ? w : FB_WIDTH - x;
      heff = (h < FB_HEIGHT - y) ? h : FB_HEIGHT - y;
    end
    if (weff == 0 || heff == 0) begin
      if (with_done) done_q.push_back(acc + 2);
      return;
    end
    n = 0;
    for (int r = 0; r < heff; r++) begin
      for (int c = 0; c < weff; c++) begin
        if (n < max_wr) begin
          e.addr = (y + r) * FB_WIDTH + (x + c);
          e.data = color;
          e.cyc  = acc + 2 + extra + n;
          wr_q.push_back(e);
        end
        n++;
      end
    end
    if (with_done) done_q.push_back(acc + 2 + extra + weff * heff);
  endtask

  // Called at a negedge. Returns acc = accepting IDLE cycle, one negedge later.
  task automatic issue(input int x, input int y, input int w, input int h,
                       input int color, input bit sync, input bit hold,
                       output int acc);
    int n;
    n = 0;
    cmd_bus.x     = 8'(x);
    cmd_bus.y     = 7'(y);
    cmd_bus.w     = 8'(w);
    cmd_bus.h     = 7'(h);
    cmd_bus.color = 12'(color);
    cmd_bus.sync  = sync;
    cmd_bus.valid = 1'b1;
    while (cmd_bus.ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    acc = cyc;
    if (cmd_bus.ready !== 1'b1) begin
      check("accept_timeout", 0, 1);
      cmd_bus.valid = 1'b0;
      return;
    end
    @(negedge clock);
    if (!hold) cmd_bus.valid = 1'b0;
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0 || cmd_bus.ready !== 1'b1)
           && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check(tag, wr_q.size() + done_q.size(), 0);
    check({tag, "_ready"}, int'(cmd_bus.ready), 1);
  endtask

  int acc;
  int a1;
  int a2;
  int n;

  initial begin
    cmd_bus.valid = 1'b0;
    cmd_bus.x     = '0;
    cmd_bus.y     = '0;
    cmd_bus.w     = '0;
    cmd_bus.h     = '0;
    cmd_bus.color = '0;
    cmd_bus.sync  = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_we",    int'(fb_we), 0);
    check("rst_addr",  int'(fb_addr), 0);
    check("rst_data",  int'(fb_data), 0);
    check("rst_done",  int'(done_irq), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_ready", int'(cmd_bus.ready), 1);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);

    // Basic fill: 162..164, 322..324 at cycles 2-7, done at 8.
    issue(2, 1, 3, 2, 'hF00, 1'b0, 1'b0, acc);
    push_expect(acc, 2, 1, 3, 2, 'hF00, 0, 1 << 20, 1'b1);
    check("basic_busy_setup", int'(busy), 1);
    wait_idle("basic_drain");

    // Clipping at the bottom-right corner: writes 19198, 19199 only.
    issue(158, 119, 10, 5, 'h0AB, 1'b0, 1'b0, acc);
    push_expect(acc, 158, 119, 10, 5, 'h0AB, 0, 1 << 20, 1'b1);
    wait_idle("clip_drain");

    // Degenerate: zero width.
    issue(10, 10, 0, 4, 'h123, 1'b0, 1'b0, acc);
    push_expect(acc, 10, 10, 0, 4, 'h123, 0, 1 << 20, 1'b1);
    wait_cycle(acc + 2);
    check("zero_w_ready_c2", int'(cmd_bus.ready), 0);
    wait_cycle(acc + 3);
    check("zero_w_ready_c3", int'(cmd_bus.ready), 1);
    wait_idle("zero_w_drain");

    // Degenerate: x off-screen.
    issue(200, 5, 8, 8, 'h456, 1'b0, 1'b0, acc);
    push_expect(acc, 200, 5, 8, 8, 'h456, 0, 1 << 20, 1'b1);
    wait_cycle(acc + 3);
    check("x200_ready_c3", int'(cmd_bus.ready), 1);
    wait_idle("x200_drain");

    // Vblank sync: v_blank low for cycles acc+2..acc+11, seen high at the
    // end of acc+12, so 11 WAIT_VB cycles; dropped again mid-fill.
    v_blank = 1'b0;
    issue(5, 5, 4, 3, 'h0F0, 1'b1, 1'b0, acc);
    push_expect(acc, 5, 5, 4, 3, 'h0F0, 11, 1 << 20, 1'b1);
    wait_cycle(acc + 12);
    check("sync_wait_busy", int'(busy), 1);
    v_blank = 1'b1;
    wait_cycle(acc + 16);
    v_blank = 1'b0;
    wait_idle("sync_drain");

    // Vblank already high on entry: exactly one WAIT_VB cycle.
    v_blank = 1'b1;
    issue(0, 0, 2, 1, 'h00F, 1'b1, 1'b0, acc);
    push_expect(acc, 0, 0, 2, 1, 'h00F, 1, 1 << 20, 1'b1);
    wait_idle("sync_hi_drain");
    v_blank = 1'b0;

    // Reset during the 500th write of a full-screen fill.
    issue(0, 0, 160, 120, 'hABC, 1'b0, 1'b0, acc);
    push_expect(acc, 0, 0, 160, 120, 'hABC, 0, 500, 1'b0);
    wait_cycle(acc + 501);
    reset = 1'b1;
    wait_cycle(acc + 502);
    reset = 1'b0;
    check("midrst_we",    int'(fb_we), 0);
    check("midrst_busy",  int'(busy), 0);
    check("midrst_addr",  int'(fb_addr), 0);
    check("midrst_ready", int'(cmd_bus.ready), 1);
    wait_cycle(acc + 510);
    check("midrst_pending", wr_q.size(), 0);
    issue(100, 50, 2, 2, 'h555, 1'b0, 1'b0, acc);
    push_expect(acc, 100, 50, 2, 2, 'h555, 0, 1 << 20, 1'b1);
    wait_idle("post_rst_drain");

    // Back-to-back 1x1 commands with cmd_valid held high.
    issue(1, 1, 1, 1, 'h111, 1'b0, 1'b1, a1);
    push_expect(a1, 1, 1, 1, 1, 'h111, 0, 1 << 20, 1'b1);
    cmd_bus.x     = 8'd10;
    cmd_bus.y     = 7'd20;
    cmd_bus.color = 12'h222;
    n = 0;
    while (cmd_bus.ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    a2 = cyc;
    check("b2b_gap", a2 - a1, 4);
    push_expect(a2, 10, 20, 1, 1, 'h222, 0, 1 << 20, 1'b1);
    @(negedge clock);
    cmd_bus.valid = 1'b0;
    wait_idle("b2b_drain");

    repeat (5) @(negedge clock);
    check("final_queues", wr_q.size() + done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_fill_engine.md
# fb_fill_engine

Framebuffer writer for the 160x120, 12-bit RGB444 framebuffer scanned out by the VGA controller. It accepts rectangle-fill commands over a valid/ready interface and writes the pixels into framebuffer port A, one pixel per clock. The VGA controller reads the same buffer on port B. Each command can optionally wait for vertical blanking, so that a fill starts without tearing. Completion is reported through a busy flag and a one-cycle done pulse for the interrupt controller.

## Interface
- FB_WIDTH, 160, pixels per framebuffer row
- FB_HEIGHT, 120, framebuffer rows
- ADDR_W, 15, framebuffer address width
- PIXEL_W, 12, pixel width (RGB444)
- clock  in  1  system clock; the only clock
- reset  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command presented
- cmd_ready  out  1  engine can accept a command
- cmd_x  in  8  left column
- cmd_y  in  7  top row
- cmd_w  in  8  width in pixels
- cmd_h  in  7  height in rows
- cmd_color  in  PIXEL_W  fill colour
- cmd_sync  in  1  1 = hold the first write until v_blank is high
- v_blank  in  1  vertical blanking flag from the VGA controller
- fb_addr  out  ADDR_W  port A address
- fb_data  out  PIXEL_W  port A write data
- fb_we  out  1  port A write enable
- busy  out  1  high whenever the state is not IDLE
- done_irq  out  1  one-cycle completion pulse

## Operation
- States are IDLE, SETUP, WAIT_VB, FILL and DONE.
- **IDLE:** cmd_ready=1. A command is accepted when cmd_valid && cmd_ready. The engine latches all cmd_* fields and goes to SETUP.
- **SETUP** (one cycle) computes:
  - base = y*160 + x, formed as (y<<7)+(y<<5)+x in ADDR_W bits. The maximum is 19199, so there is no overflow.
  - w_eff = min(w, FB_WIDTH-x) and h_eff = min(h, FB_HEIGHT-y), using 9-bit arithmetic.
  - If x>=FB_WIDTH or y>=FB_HEIGHT, the area is forced to 0.
- **SETUP transitions:**
  - Zero area (w_eff==0 or h_eff==0): go to DONE. No writes occur.
  - Otherwise, if sync=1: go to WAIT_VB.
  - Otherwise: go to FILL.
- **WAIT_VB:** stay until v_blank==1 is sampled, then go to FILL. If v_blank is already high on entry, WAIT_VB lasts exactly one cycle.
- **FILL:** fb_we=1 on every cycle, with fb_data=color. Address sequence:
  - Start at base and increment by 1 along the row.
  - After column w_eff-1, the next address is row_base+FB_WIDTH, and row_base is updated.
  - The fill ends after row h_eff-1, then goes to DONE.
  - There are no bubbles: exactly w_eff*h_eff write cycles.
  - v_blank falling during FILL does not pause or abort the fill.
- **DONE** (one cycle): done_irq=1, fb_we=0, then go to IDLE.
- cmd_* inputs are ignored outside IDLE. cmd_valid held high across DONE is accepted on the first IDLE cycle.

## Timing
- All outputs are registered. cmd_ready and busy are decoded from the state register.
- **Reset values:** state IDLE, cmd_ready=1 on the cycle after reset, busy=0, fb_we=0, fb_addr=0, fb_data=0, done_irq=0.
- **Reset mid-operation:** the write in flight completes at that edge. fb_we is 0 from the next edge. No done_irq is issued for the aborted command.
- **Latency without sync** (command accepted at edge 0):
  - SETUP at cycle 1.
  - First write at cycle 2.
  - Last write at cycle 1+w_eff*h_eff.
  - done_irq at cycle 2+w_eff*h_eff.
  - cmd_ready high again at cycle 3+w_eff*h_eff.
- **Latency with sync:** add the number of WAIT_VB cycles, which is at least 1.
- **Zero-area command:** SETUP at cycle 1, done_irq at cycle 2.
- **Back-to-back commands:** minimum spacing is area+3 cycles.
- **Framebuffer port A:** sees a write when fb_we=1 at a clock edge. Read-during-write hazards on port B are the RAM's responsibility.

## Structure
- Shared include/package `fb_pkg`:
  - FB_WIDTH, FB_HEIGHT, ADDR_W, PIXEL_W.
  - State encodings: IDLE=0, SETUP=1, WAIT_VB=2, FILL=3, DONE=4, in a 3-bit register.
  - The VGA controller uses the same package for its framebuffer geometry.
- Sub-module `fb_addr_gen`:
  - Inputs: base, w_eff, h_eff, start, step.
  - Contents: column counter, row counter, row_base, address.
  - Output: last, which flags the final pixel.
- The top level holds the FSM, command latch, clipping and output registers.

## Test plan
- **Basic fill:** x=2, y=1, w=3, h=2, color=12'hF00, sync=0.
  - Writes to 162,163,164,322,323,324 at cycles 2-7, all with data F00.
  - done_irq at cycle 8.
- **Clipping:** x=158, y=119, w=10, h=5.
  - Exactly two writes, to 19198 and 19199.
  - Then done_irq.
- **Degenerate commands:** w=0, or x=200.
  - No fb_we.
  - done_irq at cycle 2; cmd_ready back at cycle 3.
- **Vblank sync:** sync=1 with v_blank low for 10 cycles after SETUP, then high.
  - First write in the cycle after v_blank is sampled high.
  - Dropping v_blank mid-fill does not stall.
- **Reset mid-fill:** full-screen fill (w=160, h=120) with reset asserted at write 500.
  - fb_we=0 from the next edge, and busy=0.
  - No done_irq.
  - A new command completes correctly afterwards.
- **Back-to-back:** cmd_valid held high with two 1x1 commands.
  - The second is accepted on the IDLE cycle after the first's done_irq.
  - Writes occur 4 cycles apart.
